// File: rtl/bram_portb_arbiter.sv
// Round-robin arbiter sharing BRAM port B between N_REQ requesters.
// One access in flight: IDLE -> ISSUE (BRAM pins driven) -> RESP (ack, read data).
// A locked owner keeps the port across back-to-back accesses while its req stays high.
//
// Handshake: req[i] is a request held high until ack[i]; we/addr/wdata are sampled
// once, at the grant. ack[i] is a one-cycle pulse in the RESP cycle; rdata is valid
// in that same cycle for a read. A requester chaining accesses presents its next
// addr/wdata during its ack cycle, because the next grant is taken at the end of it.
module bram_portb_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 12,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic [1:0]          grant_id,
  output logic                busy,
  output logic                bram_en,
  output logic                bram_we,
  output logic [AW-1:0]       bram_addr,
  output logic [DW-1:0]       bram_din,
  input  logic [DW-1:0]       bram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic             we_lat_q, we_lat_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             bram_en_q, bram_en_d;
  logic             bram_we_q, bram_we_d;
  logic [AW-1:0]    bram_addr_q, bram_addr_d;
  logic [DW-1:0]    bram_din_q, bram_din_d;

  logic [N_REQ-1:0] win_mask;
  logic [N_REQ-1:0] cand;
  logic             others;
  logic             do_grant;
  logic [1:0]       pick;

  // First requester with its bit set, searching from ptr upward modulo N_REQ.
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] ptr);
    logic [1:0] sel;
    logic [1:0] idx;
    logic       found;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = 2'((int'(ptr) + k) % N_REQ);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return 2'((int'(p) + 1) % N_REQ);
  endfunction

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    we_lat_d    = we_lat_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    bram_en_d   = 1'b0;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    win_mask    = '0;
    win_mask[grant_id_q] = 1'b1;
    others      = |(req & ~win_mask);
    cand        = req;
    do_grant    = 1'b0;
    pick        = grant_id_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          do_grant = 1'b1;
          pick     = rr_pick(req, rr_ptr_q);
          rr_ptr_d = next_ptr(pick);
        end
      end
      S_ISSUE: begin
        state_d = S_RESP;
        ack_d   = win_mask;
      end
      S_RESP: begin
        if (!we_lat_q) rdata_d = bram_dout;
        if (lock[grant_id_q] && req[grant_id_q]) begin
          // Burst continues: same owner, pointer stays just past it.
          do_grant = 1'b1;
        end else begin
          // The finishing owner only competes when nobody else is waiting.
          cand = others ? (req & ~win_mask) : req;
          if (|cand) begin
            do_grant = 1'b1;
            pick     = rr_pick(cand, rr_ptr_q);
            rr_ptr_d = next_ptr(pick);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_grant) begin
      state_d     = S_ISSUE;
      grant_id_d  = pick;
      we_lat_d    = we[pick];
      bram_en_d   = 1'b1;
      bram_we_d   = we[pick];
      bram_addr_d = addr[int'(pick)*AW +: AW];
      bram_din_d  = wdata[int'(pick)*DW +: DW];
    end
  end

  // State and output registers; reset aborts any access and drops the BRAM pins at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      we_lat_q    <= 1'b0;
      ack_q       <= '0;
      rdata_q     <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      we_lat_q    <= we_lat_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  // Read data comes straight from the BRAM in the ack cycle, then is held.
  assign rdata     = (state_q == S_RESP && !we_lat_q) ? bram_dout : rdata_q;
  assign ack       = ack_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != S_IDLE);
  assign bram_en   = bram_en_q;
  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Bench for bram_portb_arbiter: BRAM model on port B, transaction-level reference
// model, per-cycle compare, directed scenarios followed by random traffic.
module tb_bram_portb_arbiter;
  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req   = '0;
  logic [N-1:0]    lock  = '0;
  logic [N-1:0]    we    = '0;
  logic [N*AW-1:0] addr  = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic [1:0]      grant_id;
  logic            busy, bram_en, bram_we;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_din;
  logic [DW-1:0]   bram_dout;

  bram_portb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  // ---------------- BRAM (read-first, 1-cycle registered read) ----------------
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] dout_r = '0;
  logic          bd_we   = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  assign bram_dout = dout_r;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      dout_r <= mem[bram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // An access granted at the end of cycle c drives the BRAM in c+1 and acks in c+2;
  // the next decision is taken at the end of the ack cycle.
  logic [DW-1:0] ref_mem [4096];
  int            m_cyc = 0, m_issue = 0, m_owner = 0, m_rr = 0, m_gid = 0;
  bit            m_active = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0, m_rdata = '0;
  logic [DW-1:0] exp_q [$];

  task automatic model_step();
    bit done, others;
    int w, i;
    if (bd_we) ref_mem[bd_addr] = bd_data;
    if (!rst_n) begin
      m_active = 0; m_rr = 0; m_gid = 0; m_we = 1'b0; m_addr = '0; m_din = '0;
      m_rdata = '0; m_cyc = 0;
    end else begin
      done = m_active && (m_cyc == m_issue + 1);
      w = -1;
      if (done) begin
        if (m_we) ref_mem[m_addr] = m_din;
        else m_rdata = ref_mem[m_addr];
        m_active = 0;
      end
      if (!m_active) begin
        if (done && lock[m_owner] && req[m_owner]) w = m_owner;
        else begin
          others = 0;
          for (int k = 0; k < N; k++) if (done && k != m_owner && req[k]) others = 1;
          for (int k = 0; k < N; k++) begin
            i = (m_rr + k) % N;
            if (w < 0 && req[i] && !(others && i == m_owner)) w = i;
          end
          if (w >= 0) m_rr = (w + 1) % N;
        end
        if (w >= 0) begin
          m_active = 1; m_issue = m_cyc + 1; m_owner = w; m_gid = w;
          m_we = we[w]; m_addr = addr[w*AW +: AW]; m_din = wdata[w*DW +: DW];
        end
      end
      m_cyc++;
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0]  ea;
      logic [DW-1:0] er;
      bit            in_ack, in_iss;
      in_iss = m_active && (m_cyc == m_issue);
      in_ack = m_active && (m_cyc == m_issue + 1);
      ea = '0;
      if (in_ack) ea[m_owner] = 1'b1;
      exp_q.push_back((in_ack && !m_we) ? ref_mem[m_addr] : m_rdata);
      er = exp_q.pop_front();
      chk("cyc_ack", ack, ea);
      chk("cyc_rdata", rdata, er);
      chk("cyc_grant_id", grant_id, m_gid);
      chk("cyc_busy", busy, m_active);
      chk("cyc_bram_en", bram_en, in_iss);
      chk("cyc_bram_we", bram_we, in_iss && m_we);
      chk("cyc_bram_addr", bram_addr, m_addr);
      chk("cyc_bram_din", bram_din, m_din);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_txn(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lk);
    req[i] = 1'b1; we[i] = w; addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d; lock[i] = lk;
  endtask

  task automatic clr(input int i);
    req[i] = 1'b0; lock[i] = 1'b0;
  endtask

  // Waits (bounded) for ack[i]; lat counts negedges after the call.
  task automatic wait_ack(input int i, input int budget, output int lat, output logic [DW-1:0] rd);
    bit got;
    got = 0; lat = 0; rd = '0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      if (ack[i]) got = 1;
    end
    if (!got) chk("ack_timeout", 0, 1);
    rd = rdata;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat, n, t, c0;
    int got [8];
    int at [8];
    logic [DW-1:0] rd;

    // Reset with backdoor preload of the addresses the bench uses.
    repeat (2) @(negedge clk);
    for (int a = 0; a < 17; a++) begin
      bd_we = 1'b1;
      bd_addr = (a == 16) ? 12'hFFF : AW'(a);
      bd_data = (a == 16) ? 8'h3C : DW'($urandom_range(0, 255));
      @(negedge clk);
    end
    bd_we = 1'b0;
    @(negedge clk);
    cmp_en = 1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single write then readback; req cycle is the 1st, ISSUE the 2nd, ack the 3rd.
    set_txn(0, 1'b1, 12'h005, 8'hA5, 1'b0);
    @(negedge clk);
    chk("t1_issue_en", bram_en, 1);
    chk("t1_issue_we", bram_we, 1);
    chk("t1_issue_addr", bram_addr, 12'h005);
    chk("t1_issue_din", bram_din, 8'hA5);
    @(negedge clk);
    chk("t1_ack", ack, 3'b001);
    clr(0);
    @(negedge clk);
    set_txn(2, 1'b0, 12'h005, 8'h00, 1'b0);
    wait_ack(2, 10, lat, rd);
    chk("t1_rd_latency", lat, 2);
    chk("t1_readback", rd, 8'hA5);
    clr(2);
    @(negedge clk);

    // 2: contention, all three held, no lock -> 0,1,2,0,1,2 every 2 cycles.
    for (int i = 0; i < N; i++) set_txn(i, 1'b0, AW'(i), 8'h00, 1'b0);
    n = 0; t = 0;
    while (n < 6 && t < 60) begin
      @(negedge clk);
      t++;
      if (ack != 0) begin got[n] = oh_idx(ack); at[n] = t; n++; end
    end
    for (int i = 0; i < N; i++) clr(i);
    chk("t2_count", n, 6);
    for (int k = 0; k < 6; k++) begin
      chk("t2_order", got[k], k % 3);
      if (k > 0) chk("t2_spacing", at[k] - at[k-1], 2);
    end
    @(negedge clk);

    // 3: locked burst of four writes by 0 while 1 waits, then 1 reads back addr 8.
    set_txn(0, 1'b1, 12'h008, 8'h10, 1'b1);
    set_txn(1, 1'b0, 12'h008, 8'h00, 1'b0);
    n = 0; t = 0; c0 = 0;
    while (n < 5 && t < 60) begin
      @(negedge clk);
      t++;
      if (ack != 0) begin
        got[n] = oh_idx(ack); at[n] = t; n++;
        if (ack[0]) begin
          c0++;
          if (c0 == 4) clr(0);
          else set_txn(0, 1'b1, AW'(8 + c0), DW'(8'h10 + c0), 1'b1);
        end
        if (ack[1]) begin rd = rdata; clr(1); end
      end
    end
    chk("t3_count", n, 5);
    for (int k = 0; k < 5; k++) begin
      chk("t3_order", got[k], (k < 4) ? 0 : 1);
      if (k > 0) chk("t3_spacing", at[k] - at[k-1], 2);
    end
    chk("t3_readback", rd, 8'h10);
    @(negedge clk);

    // 4: read of the preloaded top address.
    set_txn(2, 1'b0, 12'hFFF, 8'h00, 1'b0);
    wait_ack(2, 10, lat, rd);
    chk("t4_rdata", rd, 8'h3C);
    clr(2);
    @(negedge clk);

    // 5: reset during ISSUE; afterwards requester 1 alone is granted first.
    set_txn(0, 1'b0, 12'h003, 8'h00, 1'b0);
    @(negedge clk);
    chk("t5_in_issue", bram_en, 1);
    #2;
    rst_n = 1'b0;
    clr(0);
    set_txn(1, 1'b0, 12'h004, 8'h00, 1'b0);
    #1;
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_rdata", rdata, 0);
    chk("t5_rst_grant", grant_id, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_en", bram_en, 0);
    chk("t5_rst_we", bram_we, 0);
    chk("t5_rst_addr", bram_addr, 0);
    chk("t5_rst_din", bram_din, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(1, 10, lat, rd);
    chk("t5_lat", lat, 2);
    chk("t5_grant", grant_id, 1);
    clr(1);
    @(negedge clk);

    // 6: req[1] pulsed for one cycle while 0 owns the port -> abandoned.
    set_txn(0, 1'b1, 12'h00C, 8'h20, 1'b1);
    wait_ack(0, 10, lat, rd);
    set_txn(0, 1'b1, 12'h00D, 8'h21, 1'b1);
    @(negedge clk);
    set_txn(1, 1'b1, 12'h00E, 8'h77, 1'b0);
    @(negedge clk);
    chk("t6_ack0", ack, 3'b001);
    clr(1);
    clr(0);
    n = 0; c0 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack[1]) n++;
      if (bram_en && bram_addr == 12'h00E) c0++;
    end
    chk("t6_no_ack1", n, 0);
    chk("t6_no_access1", c0, 0);

    // Random traffic over addresses 0..15.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (ack[i]) begin
            if ($urandom_range(0, 2) == 0) clr(i);
            else set_txn(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                         DW'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
          end else if ($urandom_range(0, 39) == 0) clr(i);
        end else if ($urandom_range(0, 3) == 0) begin
          set_txn(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                  DW'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
        end
      end
    end
    for (int i = 0; i < N; i++) clr(i);
    repeat (6) @(negedge clk);
    chk("drain_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
